// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the CPU-side and memory-side signals of mem_arbiter.
//   fetch port : if_req, if_addr -> if_ready, if_rvalid, if_rdata
//   data port  : d_req, d_we, d_be, d_addr, d_wdata -> d_ready, d_rvalid, d_rdata
//   memory     : mem_en, mem_we, mem_be, mem_addr, mem_wdata <- mem_rdata
//   status     : busy
// Modports: slave = arbiter view, master = environment (CPU + memory) view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      if_req;
  logic [ADDR_WIDTH-1:0]     if_addr;
  logic                      if_ready;
  logic                      if_rvalid;
  logic [DATA_WIDTH-1:0]     if_rdata;
  logic                      d_req;
  logic                      d_we;
  logic [DATA_WIDTH/8-1:0]   d_be;
  logic [ADDR_WIDTH-1:0]     d_addr;
  logic [DATA_WIDTH-1:0]     d_wdata;
  logic                      d_ready;
  logic                      d_rvalid;
  logic [DATA_WIDTH-1:0]     d_rdata;
  logic                      mem_en;
  logic                      mem_we;
  logic [DATA_WIDTH/8-1:0]   mem_be;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic                      busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between the CPU fetch port
// and the CPU load/store port. One access is outstanding at a time and is
// sequenced IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : mem_arbiter_if.slave (fetch port, data port, memory port, busy)
// Parameters: ADDR_WIDTH, DATA_WIDTH, MEM_LATENCY (1..15).
// Optional build macro MEM_ARB_FIXED_PRIO_EN: when defined the data port wins
// every tie; otherwise ties are resolved round-robin.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int         BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                  state_r;
  logic                    last_grant_r;  // 1 = data port, 0 = fetch port
  logic                    owner_r;       // port owning the access in flight
  logic                    owner_we_r;    // access in flight is a write
  logic [3:0]              cnt_r;
  logic                    if_ready_r;
  logic                    if_rvalid_r;
  logic [DATA_WIDTH-1:0]   if_rdata_r;
  logic                    d_ready_r;
  logic                    d_rvalid_r;
  logic [DATA_WIDTH-1:0]   d_rdata_r;
  logic                    mem_en_r;
  logic                    mem_we_r;
  logic [BE_WIDTH-1:0]     mem_be_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic [DATA_WIDTH-1:0]   mem_wdata_r;
  logic                    busy_r;
  logic                    any_req_s;
  logic                    pick_data_s;

  // Winner selection for a request sampled in IDLE (1 = data port)
  always_comb begin
    any_req_s   = bus.if_req | bus.d_req;
    pick_data_s = 1'b0;
    if (bus.if_req && bus.d_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      pick_data_s = 1'b1;
`else
      pick_data_s = ~last_grant_r;
`endif
    end else if (bus.d_req) begin
      pick_data_s = 1'b1;
    end else begin
      pick_data_s = 1'b0;
    end
  end

  // Access sequencer; every output is a register updated here
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      owner_we_r   <= 1'b0;
      cnt_r        <= 4'd0;
      if_ready_r   <= 1'b0;
      if_rvalid_r  <= 1'b0;
      if_rdata_r   <= {DATA_WIDTH{1'b0}};
      d_ready_r    <= 1'b0;
      d_rvalid_r   <= 1'b0;
      d_rdata_r    <= {DATA_WIDTH{1'b0}};
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_be_r     <= {BE_WIDTH{1'b0}};
      mem_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r  <= {DATA_WIDTH{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      // Pulse outputs fall back to 0 unless a state below raises them
      if_ready_r  <= 1'b0;
      d_ready_r   <= 1'b0;
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            owner_r      <= pick_data_s;
            last_grant_r <= pick_data_s;
            mem_en_r     <= 1'b1;
            busy_r       <= 1'b1;
            state_r      <= ST_ISSUE;
            if (pick_data_s) begin
              owner_we_r  <= bus.d_we;
              mem_we_r    <= bus.d_we;
              mem_be_r    <= bus.d_be;
              mem_addr_r  <= bus.d_addr;
              mem_wdata_r <= bus.d_wdata;
              d_ready_r   <= 1'b1;
            end else begin
              owner_we_r  <= 1'b0;
              mem_we_r    <= 1'b0;
              mem_be_r    <= {BE_WIDTH{1'b1}};
              mem_addr_r  <= bus.if_addr;
              mem_wdata_r <= {DATA_WIDTH{1'b0}};
              if_ready_r  <= 1'b1;
            end
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          cnt_r   <= LAT_LOAD;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // Counter reaching 0 marks the cycle in which mem_rdata is valid
          if (cnt_r == 4'd0) begin
            state_r <= ST_RESP;
            if (owner_r) begin
              d_rvalid_r <= 1'b1;
              d_rdata_r  <= owner_we_r ? {DATA_WIDTH{1'b0}} : bus.mem_rdata;
            end else begin
              if_rvalid_r <= 1'b1;
              if_rdata_r  <= bus.mem_rdata;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.if_ready  = if_ready_r;
  assign bus.if_rvalid = if_rvalid_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_ready   = d_ready_r;
  assign bus.d_rvalid  = d_rvalid_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_be    = mem_be_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiter instances (MEM_LATENCY 1 and 4), each with a
// latency-accurate memory and a timeline model that schedules the expected
// output values of every cycle; directed vectors add literal expectations.
module tb_mem_arbiter;
  typedef struct packed {
    logic        ifr, dr, ifv, dv, en, we, busy, rst, chkw;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int tests_run = 0;
  int fails = 0;

  logic [1:0]  rst_v = 2'b11;
  logic [1:0]  if_req_v = 2'b00, d_req_v = 2'b00, d_we_v = 2'b00;
  logic [31:0] if_addr_v [2];
  logic [31:0] d_addr_v  [2];
  logic [31:0] d_wdata_v [2];
  logic [3:0]  d_be_v    [2];
  logic [1:0]  if_ready_w, d_ready_w, if_rvalid_w, d_rvalid_w, busy_w;
  logic [31:0] if_rdata_w [2];
  logic [31:0] d_rdata_w  [2];

  // Edge counter: after edge n, cyc == n + 1
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] sl(input int c);
    return c[5:0];
  endfunction

  function automatic logic pick_fn(input logic ifr, input logic dr, input logic lg);
    if (ifr && dr) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      return 1'b1 | lg;
`else
      return ~lg;
`endif
    end
    return dr;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 4;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (rst_v[g]),
      .bus   (bus)
    );

    assign bus.if_req   = if_req_v[g];
    assign bus.if_addr  = if_addr_v[g];
    assign bus.d_req    = d_req_v[g];
    assign bus.d_we     = d_we_v[g];
    assign bus.d_be     = d_be_v[g];
    assign bus.d_addr   = d_addr_v[g];
    assign bus.d_wdata  = d_wdata_v[g];
    assign if_ready_w[g]  = bus.if_ready;
    assign d_ready_w[g]   = bus.d_ready;
    assign if_rvalid_w[g] = bus.if_rvalid;
    assign d_rvalid_w[g]  = bus.d_rvalid;
    assign busy_w[g]      = bus.busy;
    assign if_rdata_w[g]  = bus.if_rdata;
    assign d_rdata_w[g]   = bus.d_rdata;

    // Memory with fixed read latency; junk on the pipe when nothing was read
    logic [31:0] marr [256];
    logic [31:0] pipe [4];
    logic [31:0] mmem [256];
    initial begin
      for (int i = 0; i < 256; i++) begin
        marr[i] <= 32'h0;
        mmem[i] <= 32'h0;
      end
      marr[8'h10] <= 32'h0000_000D;
      mmem[8'h10] <= 32'h0000_000D;
    end
    always @(posedge clk) begin
      if (bus.mem_en) begin
        pipe[0] <= marr[bus.mem_addr[7:0]];
        if (bus.mem_we) marr[bus.mem_addr[7:0]] <= merge(marr[bus.mem_addr[7:0]], bus.mem_wdata, bus.mem_be);
      end else begin
        pipe[0] <= 32'hBAD0_BAD0;
      end
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    // Timeline model: ring of expected outputs per edge index
    exp_t        ex [64];
    logic        lg = 1'b1;
    int          free_edge = 0;
    logic        pick_s;
    logic [31:0] paddr_s, prd_s;
    always_comb begin
      pick_s  = pick_fn(if_req_v[g], d_req_v[g], lg);
      paddr_s = pick_s ? d_addr_v[g] : if_addr_v[g];
      prd_s   = mmem[paddr_s[7:0]];
    end
    always @(posedge clk) begin
      ex[sl(cyc + 40)] <= '0;
      if (rst_v[g]) begin
        for (int i = 0; i < 40; i++) ex[sl(cyc + i)] <= '0;
        ex[sl(cyc)].rst <= 1'b1;
        lg        <= 1'b1;
        free_edge <= cyc + 1;
      end else if (cyc >= free_edge && (if_req_v[g] || d_req_v[g])) begin
        lg        <= pick_s;
        free_edge <= cyc + LAT + 3;
        for (int i = 0; i <= LAT + 1; i++) ex[sl(cyc + i)].busy <= 1'b1;
        ex[sl(cyc)].ifr   <= ~pick_s;
        ex[sl(cyc)].dr    <= pick_s;
        ex[sl(cyc)].en    <= 1'b1;
        ex[sl(cyc)].we    <= pick_s & d_we_v[g];
        ex[sl(cyc)].be    <= pick_s ? d_be_v[g] : 4'hF;
        ex[sl(cyc)].addr  <= paddr_s;
        ex[sl(cyc)].wdata <= d_wdata_v[g];
        ex[sl(cyc)].chkw  <= pick_s;
        ex[sl(cyc + 1 + LAT)].ifv   <= ~pick_s;
        ex[sl(cyc + 1 + LAT)].dv    <= pick_s;
        ex[sl(cyc + 1 + LAT)].rdata <= (pick_s && d_we_v[g]) ? 32'h0 : prd_s;
        if (pick_s && d_we_v[g])
          mmem[d_addr_v[g][7:0]] <= merge(mmem[d_addr_v[g][7:0]], d_wdata_v[g], d_be_v[g]);
      end
    end

    // Compare process: outputs after the latest edge against the model
    exp_t        e_s;
    logic [31:0] held_if, held_d, exp_ifd_s, exp_dd_s;
    always_comb begin
      e_s       = ex[sl(cyc + 63)];
      exp_ifd_s = e_s.rst ? 32'h0 : (e_s.ifv ? e_s.rdata : held_if);
      exp_dd_s  = e_s.rst ? 32'h0 : (e_s.dv ? e_s.rdata : held_d);
    end
    always @(negedge clk) begin
      if (cyc > 0) begin
        check($sformatf("L%0d if_ready", g),  32'(bus.if_ready),  32'(e_s.ifr));
        check($sformatf("L%0d d_ready", g),   32'(bus.d_ready),   32'(e_s.dr));
        check($sformatf("L%0d if_rvalid", g), 32'(bus.if_rvalid), 32'(e_s.ifv));
        check($sformatf("L%0d d_rvalid", g),  32'(bus.d_rvalid),  32'(e_s.dv));
        check($sformatf("L%0d mem_en", g),    32'(bus.mem_en),    32'(e_s.en));
        check($sformatf("L%0d mem_we", g),    32'(bus.mem_we),    32'(e_s.we));
        check($sformatf("L%0d busy", g),      32'(bus.busy),      32'(e_s.busy));
        check($sformatf("L%0d if_rdata", g),  bus.if_rdata, exp_ifd_s);
        check($sformatf("L%0d d_rdata", g),   bus.d_rdata,  exp_dd_s);
        if (e_s.en || e_s.rst) begin
          check($sformatf("L%0d mem_addr", g), bus.mem_addr,     e_s.addr);
          check($sformatf("L%0d mem_be", g),   32'(bus.mem_be),  32'(e_s.be));
        end
        if ((e_s.en && e_s.chkw) || e_s.rst)
          check($sformatf("L%0d mem_wdata", g), bus.mem_wdata, e_s.wdata);
        held_if <= exp_ifd_s;
        held_d  <= exp_dd_s;
      end
    end
  end

  // One bounded access on lane l; latencies counted in cycles from raising req
  task automatic access(input int l, input bit dport, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int rdy_lat, output int rv_lat);
    int n;
    bit got;
    rdata = 32'hFFFF_FFFF;
    rdy_lat = -1;
    rv_lat = -1;
    @(negedge clk);
    if (dport) begin
      d_req_v[l] = 1'b1; d_we_v[l] = we; d_be_v[l] = be; d_addr_v[l] = addr; d_wdata_v[l] = wdata;
    end else begin
      if_req_v[l] = 1'b1; if_addr_v[l] = addr;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (dport ? d_ready_w[l] : if_ready_w[l]) begin got = 1'b1; rdy_lat = n; end
    end
    if (dport) d_req_v[l] = 1'b0; else if_req_v[l] = 1'b0;
    got = 1'b0;
    while (!got && n < 80) begin
      @(negedge clk);
      n++;
      if (dport ? d_rvalid_w[l] : if_rvalid_w[l]) begin
        got = 1'b1;
        rv_lat = n;
        rdata = dport ? d_rdata_w[l] : if_rdata_w[l];
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    int rl, vl, ng, nb, rvat, nrv;
    logic gport [3];
    int gat [3];
    for (int l = 0; l < 2; l++) begin
      if_addr_v[l] = 32'h0; d_addr_v[l] = 32'h0; d_wdata_v[l] = 32'h0; d_be_v[l] = 4'h0;
    end
    repeat (3) @(negedge clk);
    rst_v = 2'b00;
    check("reset busy", 32'(busy_w), 32'h0);
    check("reset if_rdata", if_rdata_w[0], 32'h0);

    access(0, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0, rd, rl, vl);
    check("fetch data", rd, 32'h0000_000D);
    check("fetch ready lat", 32'(rl), 32'd1);
    check("fetch rvalid lat", 32'(vl), 32'd3);
    access(0, 1'b1, 1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF, rd, rl, vl);
    check("write rdata", rd, 32'h0);
    check("write rvalid lat", 32'(vl), 32'd3);
    access(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, rd, rl, vl);
    check("read after write", rd, 32'hDEAD_BEEF);
    access(0, 1'b1, 1'b1, 4'h1, 32'h20, 32'h0000_00AA, rd, rl, vl);
    access(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, rd, rl, vl);
    check("byte write readback", rd, 32'hDEAD_BEAA);
    access(0, 1'b1, 1'b1, 4'h0, 32'h20, 32'h1234_5678, rd, rl, vl);
    check("be0 write acked", 32'(vl), 32'd3);
    access(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, rd, rl, vl);
    check("be0 write no effect", rd, 32'hDEAD_BEAA);
    access(0, 1'b0, 1'b0, 4'h0, 32'h1234_5610, 32'h0, rd, rl, vl);
    check("fetch high addr", rd, 32'h0000_000D);

    // Both ports held high from reset
    @(negedge clk);
    rst_v[0] = 1'b1;
    d_we_v[0] = 1'b0; d_addr_v[0] = 32'h20; if_addr_v[0] = 32'h10;
    if_req_v[0] = 1'b1; d_req_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    ng = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (if_ready_w[0] || d_ready_w[0]) begin
        if (ng < 3) begin gport[ng] = d_ready_w[0]; gat[ng] = k; end
        ng++;
      end
    end
    if_req_v[0] = 1'b0; d_req_v[0] = 1'b0;
    check("tie grant count", 32'(ng), 32'd4);
`ifdef MEM_ARB_FIXED_PRIO_EN
    check("tie grant0 port", 32'(gport[0]), 32'd1);
    check("tie grant1 port", 32'(gport[1]), 32'd1);
    check("tie grant2 port", 32'(gport[2]), 32'd1);
`else
    check("tie grant0 port", 32'(gport[0]), 32'd0);
    check("tie grant1 port", 32'(gport[1]), 32'd1);
    check("tie grant2 port", 32'(gport[2]), 32'd0);
`endif
    check("tie grant0 at", 32'(gat[0]), 32'd1);
    check("tie grant spacing", 32'(gat[1] - gat[0]), 32'd4);
    check("tie grant spacing2", 32'(gat[2] - gat[1]), 32'd4);
    repeat (6) @(negedge clk);

    // Reset while waiting for the memory
    if_req_v[0] = 1'b1; if_addr_v[0] = 32'h10;
    @(negedge clk);
    check("abort ready", 32'(if_ready_w[0]), 32'd1);
    if_req_v[0] = 1'b0;
    @(negedge clk);
    check("abort busy in wait", 32'(busy_w[0]), 32'd1);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    check("abort busy", 32'(busy_w[0]), 32'd0);
    check("abort if_rvalid", 32'(if_rvalid_w[0]), 32'd0);
    check("abort if_rdata", if_rdata_w[0], 32'h0);
    nrv = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (if_rvalid_w[0] || d_rvalid_w[0]) nrv++;
    end
    check("abort no rvalid", 32'(nrv), 32'd0);
    access(0, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0, rd, rl, vl);
    check("after abort data", rd, 32'h0000_000D);
    check("after abort rvalid lat", 32'(vl), 32'd3);

    // MEM_LATENCY = 4 lane
    @(negedge clk);
    if_req_v[1] = 1'b1; if_addr_v[1] = 32'h10;
    nb = 0; rvat = -1; rd = 32'hFFFF_FFFF;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (if_ready_w[1]) if_req_v[1] = 1'b0;
      if (busy_w[1]) nb++;
      if (if_rvalid_w[1] && rvat < 0) begin rvat = k; rd = if_rdata_w[1]; end
    end
    if_req_v[1] = 1'b0;
    check("L4 busy cycles", 32'(nb), 32'd6);
    check("L4 rvalid at", 32'(rvat), 32'd6);
    check("L4 fetch data", rd, 32'h0000_000D);
    access(1, 1'b1, 1'b1, 4'b0110, 32'h40, 32'h1122_3344, rd, rl, vl);
    check("L4 write rvalid lat", 32'(vl), 32'd6);
    access(1, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, rd, rl, vl);
    check("L4 partial readback", rd, 32'h0022_3300);
    check("L4 ready lat", 32'(rl), 32'd1);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the SoC's single-port word memory between the CPU instruction-fetch port and the CPU load/store data port.
- Sequences each access as issue, wait for the fixed memory latency, then return the response.
- Ties are arbitrated round-robin.
- Sits between cpu and the memory inside soc; one access is outstanding at a time.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of data buses; byte enables are DATA_WIDTH/8 bits
MEM_LATENCY, 1, cycles from mem_en high to mem_rdata valid; legal range 1..15

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held with if_addr stable until if_ready
if_addr  input  ADDR_WIDTH  fetch word address
if_ready  output  1  one-cycle pulse: fetch request accepted
if_rvalid  output  1  one-cycle pulse: if_rdata valid
if_rdata  output  DATA_WIDTH  fetched word
d_req  input  1  data request; held with d_* stable until d_ready
d_we  input  1  1 = write, 0 = read
d_be  input  DATA_WIDTH/8  write byte enables
d_addr  input  ADDR_WIDTH  data address
d_wdata  input  DATA_WIDTH  write data
d_ready  output  1  one-cycle pulse: data request accepted
d_rvalid  output  1  one-cycle pulse: read data valid, or write done
d_rdata  output  DATA_WIDTH  read data; 0 for writes
mem_en  output  1  memory access strobe, one cycle per access
mem_we  output  1  memory write enable
mem_be  output  DATA_WIDTH/8  memory byte enables
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en
busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. On reset every output is 0, state = IDLE, last_grant = DATA (so fetch wins the first tie), latency counter = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high at edge T, pick the winner and latch its addr/we/be/wdata.
  - Go to ISSUE; the winner's ready pulses at T+1.
  - With no request, stay in IDLE.
- Winner selection:
  - Only one req high: that port wins.
  - Both high: the port opposite last_grant wins, then last_grant is updated.
- ISSUE (1 cycle):
  - mem_en=1 with the latched mem_we/mem_be/mem_addr/mem_wdata.
  - A fetch drives mem_we=0 and mem_be all-ones.
  - Counter loads MEM_LATENCY-1; go to WAIT.
- WAIT:
  - mem_en=0, mem_we=0.
  - Decrement the counter; when it is 0 and mem_rdata is valid, capture mem_rdata (or 0 for a write) and go to RESP.
- RESP (1 cycle):
  - Owner's rvalid=1 and rdata = captured value; return to IDLE.
  - rdata holds its value until the next response.
- Latency: req sampled at T gives mem_en at T+1 and rvalid at T+2+MEM_LATENCY.
- Throughput: one access per MEM_LATENCY+3 cycles.
- Requests seen while not in IDLE are ignored; the requester keeps req high and is served later.
- If req drops before being sampled in IDLE, no access is made. Once sampled, the access always completes.
- A write with be=0 is still issued and still acknowledged with rvalid.
- Addresses pass through unmodified; no alignment check.
- Reset mid-access: back to IDLE next edge, the pending response is dropped, and no rvalid is generated.
- Only one of if_ready/d_ready, and one of if_rvalid/d_rvalid, is ever high in a cycle.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: the data port always wins a tie (fixed priority, so load/store never stalls behind a fetch). last_grant is still updated but does not affect selection.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Read: memory word 0x00000010 = 0x0000000D; if_req at T with if_addr=0x10, MEM_LATENCY=1 -> if_ready at T+1, mem_en at T+1, if_rvalid at T+3 with if_rdata=0x0000000D.
- Write then read:
  - d_req write 0xDEADBEEF to 0x20, be=4'b1111 -> mem_we=1 for one cycle, d_rvalid with d_rdata=0.
  - Then d_req read of 0x20 -> d_rdata=0xDEADBEEF.
  - Then a write of 0x000000AA with be=4'b0001 -> readback 0xDEADBEAA.
- Tie, round-robin:
  - if_req and d_req held high together from reset -> fetch served first, then data, then fetch.
  - Grants alternate; the ready pulses are MEM_LATENCY+3 cycles apart.
- Tie, MEM_ARB_FIXED_PRIO_EN defined: same stimulus -> data served on every tie; fetch is served only once d_req drops.
- Reset mid-access: assert reset during WAIT -> the following cycle all outputs are 0, busy=0, and no rvalid ever appears for the aborted access. A new request afterwards completes normally.
- MEM_LATENCY=4: single fetch -> if_rvalid exactly 6 cycles after if_req is sampled. busy is high for exactly 6 cycles.
